// File: rtl/adc_serial_responder.sv
// adc_serial_responder
//
// Responder end of a dual 12-bit serial ADC read interface. It stands in for
// the physical converter during loopback and simulation of the sensor
// readout path. The FPGA-side controller drives chip_select and ADC_clk. This
// block answers with two serial data streams. Each frame is LEAD_ZEROS zero
// bits followed by the DATA_WIDTH-bit result, sent MSB first. Both control
// inputs are asynchronous and are oversampled on fpga_clk.
//
// Ports:
//   fpga_clk     in   system clock, at least 8x the ADC_clk frequency
//   reset        in   synchronous, active-high
//   ADC_clk      in   serial clock from the controller (asynchronous)
//   chip_select  in   active-low frame enable from the controller (asynchronous)
//   pattern_en   in   1 = ramp pattern from the pixel index, 0 = sample inputs
//   sample1      in   channel 1 conversion value
//   sample2      in   channel 2 conversion value
//   serial_data1 out  channel 1 serial data
//   serial_data2 out  channel 2 serial data
//   frame_done   out  one-cycle pulse when a complete frame is closed
//   frame_abort  out  one-cycle pulse when chip_select rises mid-frame
//   frame_count  out  number of completed frames, wrapping at 16 bits

module adc_serial_responder #(
  parameter int DATA_WIDTH  = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PIXELS      = 128
) (
  input  logic                  fpga_clk,
  input  logic                  reset,
  input  logic                  ADC_clk,
  input  logic                  chip_select,
  input  logic                  pattern_en,
  input  logic [DATA_WIDTH-1:0] sample1,
  input  logic [DATA_WIDTH-1:0] sample2,
  output logic                  serial_data1,
  output logic                  serial_data2,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic [15:0]           frame_count
);

  localparam int FRAME_LEN = LEAD_ZEROS + DATA_WIDTH;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int IDX_W     = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_PIXEL = IDX_W'(PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  // Synchronizer chains and edge-detect flops. They reset to the idle-high
  // level of both pins, so no spurious edge is seen when reset is released.
  logic [SYNC_STAGES-1:0] csSync_q;
  logic [SYNC_STAGES-1:0] clkSync_q;
  logic                   csPrev_q;
  logic                   clkPrev_q;

  logic csSynced;
  logic clkSynced;
  logic csFall;
  logic csRise;
  logic clkFall;

  // Frame state and datapath registers with their next-state values.
  state_t                 state_q,      state_d;
  logic [FRAME_LEN-1:0]   shift1_q,     shift1_d;
  logic [FRAME_LEN-1:0]   shift2_q,     shift2_d;
  logic [CNT_W-1:0]       bitCnt_q,     bitCnt_d;
  logic [IDX_W-1:0]       index_q,      index_d;
  logic [15:0]            frameCount_q, frameCount_d;
  logic                   done_q,       done_d;
  logic                   abort_q,      abort_d;

  logic [DATA_WIDTH-1:0]  src1;
  logic [DATA_WIDTH-1:0]  src2;

  // Bring both asynchronous control pins into the fpga_clk domain. Then keep
  // one more flop of history so each edge is seen as a single-cycle event.
  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      csSync_q  <= '1;
      clkSync_q <= '1;
      csPrev_q  <= 1'b1;
      clkPrev_q <= 1'b1;
    end else begin
      csSync_q  <= SYNC_STAGES'({csSync_q, chip_select});
      clkSync_q <= SYNC_STAGES'({clkSync_q, ADC_clk});
      csPrev_q  <= csSync_q[SYNC_STAGES-1];
      clkPrev_q <= clkSync_q[SYNC_STAGES-1];
    end
  end

  assign csSynced  = csSync_q[SYNC_STAGES-1];
  assign clkSynced = clkSync_q[SYNC_STAGES-1];
  assign csFall    = csPrev_q & ~csSynced;
  assign csRise    = ~csPrev_q & csSynced;
  assign clkFall   = clkPrev_q & ~clkSynced;

  // Pick the values to be loaded at the start of a frame. In pattern mode
  // channel 1 carries the pixel index. Channel 2 carries its complement, so
  // the two channels ramp in opposite directions.
  always_comb begin
    src1 = sample1;
    src2 = sample2;
    if (pattern_en) begin
      src1 = DATA_WIDTH'(index_q);
      src2 = ~DATA_WIDTH'(index_q);
    end
  end

  // State register for the frame FSM and its datapath.
  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift1_q     <= '0;
      shift2_q     <= '0;
      bitCnt_q     <= '0;
      index_q      <= '0;
      frameCount_q <= '0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift1_q     <= shift1_d;
      shift2_q     <= shift2_d;
      bitCnt_q     <= bitCnt_d;
      index_q      <= index_d;
      frameCount_q <= frameCount_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end

  // Next-state logic. A chip_select edge is checked before an ADC_clk edge
  // in every state. When both arrive in the same cycle, the frame boundary
  // wins and the clock edge is dropped. Only falling ADC_clk edges move the
  // data, because the controller samples on the rising edges.
  always_comb begin
    state_d      = state_q;
    shift1_d     = shift1_q;
    shift2_d     = shift2_q;
    bitCnt_d     = bitCnt_q;
    index_d      = index_q;
    frameCount_d = frameCount_q;
    done_d       = 1'b0;
    abort_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (csFall) begin
          shift1_d = FRAME_LEN'(src1);
          shift2_d = FRAME_LEN'(src2);
          bitCnt_d = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (csRise) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (clkFall) begin
          if (bitCnt_q == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            shift1_d = shift1_q << 1;
            shift2_d = shift2_q << 1;
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
      end

      HOLD: begin
        if (csRise) begin
          done_d       = 1'b1;
          frameCount_d = frameCount_q + 16'd1;
          index_d      = (index_q == LAST_PIXEL) ? '0 : index_q + IDX_W'(1);
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The data lines follow the shift-register MSB only while a frame is being
  // shifted. They are held low in IDLE and once all bits have gone out.
  assign serial_data1 = (state_q == SHIFT) && shift1_q[FRAME_LEN-1];
  assign serial_data2 = (state_q == SHIFT) && shift2_q[FRAME_LEN-1];
  assign frame_done   = done_q;
  assign frame_abort  = abort_q;
  assign frame_count  = frameCount_q;

endmodule
